// File: rtl/signature_analyzer_if.sv
// Product handshake and result bus between the multiplier BIST harness and the signature analyzer.
interface signature_analyzer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] expected_signature;
  logic [DATA_W-1:0] signature;
  logic [CNT_W-1:0]  count;
  logic              done;
  logic              pass;

  modport master (
    output in_valid, product, expected_signature,
    input  in_ready, signature, count, done, pass
  );

  modport slave (
    input  in_valid, product, expected_signature,
    output in_ready, signature, count, done, pass
  );
endinterface

// File: rtl/signature_analyzer.sv
// BIST response compactor: folds multiplier products into a 16-bit MISR and
// compares the final signature against a golden value.
module signature_analyzer #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_RESULTS = 32,
  parameter logic [DATA_W-1:0] SEED        = DATA_W'(16'h8000),
  parameter logic [DATA_W-1:0] TAPS        = DATA_W'(16'h002C)
) (
  input  logic                 clk,
  input  logic                 reset_to_analyzer,
  signature_analyzer_if.slave  bus
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_signature;
  logic [CNT_W-1:0]  r_count;
  logic              r_done;
  logic              r_pass;

  logic              w_accept;
  logic              w_last;
  logic [DATA_W-1:0] w_feedback;
  logic [DATA_W-1:0] w_misr_next;

  assign w_accept    = (r_state == S_COLLECT) && bus.in_valid;
  assign w_last      = (r_count == CNT_W'(NUM_RESULTS - 1));
  // Bit 0 always takes the feedback term in addition to the tap mask.
  assign w_feedback  = r_signature[DATA_W-1] ? (TAPS | DATA_W'(1)) : '0;
  assign w_misr_next = {r_signature[DATA_W-2:0], 1'b0} ^ w_feedback ^ bus.product;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_to_analyzer) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_COLLECT: if (w_accept && w_last) w_state_next = S_COMPARE;
      S_COMPARE: w_state_next = S_DONE;
      S_DONE:    w_state_next = S_DONE;
      default:   w_state_next = S_COLLECT;
    endcase
  end

  // Output logic: ready depends on state only
  always_comb begin
    bus.in_ready = 1'b0;
    if (r_state == S_COLLECT) bus.in_ready = 1'b1;
  end

  // MISR, product counter and verdict registers
  always_ff @(posedge clk) begin
    if (!reset_to_analyzer) begin
      r_signature <= SEED;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_signature <= w_misr_next;
        r_count     <= r_count + CNT_W'(1);
      end
      if (r_state == S_COMPARE) begin
        r_pass <= (r_signature == bus.expected_signature);
        r_done <= 1'b1;
      end
    end
  end

  assign bus.signature = r_signature;
  assign bus.count     = r_count;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;

endmodule

// File: tb/tb_signature_analyzer.sv
// Scoreboard bench for signature_analyzer: driver pushes expectations from a
// polynomial-arithmetic MISR model, a monitor pops them on every accept and on done.
module tb_signature_analyzer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM    = 32;
  localparam logic [15:0] SEED   = 16'h8000;

  typedef struct {
    logic [15:0] sig;
    logic [5:0]  cnt;
  } acc_t;

  typedef struct {
    logic        pass;
    logic [15:0] sig;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  signature_analyzer_if #(.DATA_W(DATA_W)) bus ();

  signature_analyzer #(
    .DATA_W      (DATA_W),
    .NUM_RESULTS (NUM),
    .SEED        (SEED),
    .TAPS        (16'h002C)
  ) dut (
    .clk               (clk),
    .reset_to_analyzer (rst_n),
    .bus               (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  acc_t acc_q[$];
  res_t done_q[$];

  logic [15:0] m_sig = SEED;
  int          m_cnt = 0;
  logic [15:0] g_exp = '0;
  logic [15:0] gen_p[NUM];
  logic [15:0] flip_p[NUM];
  logic [15:0] golden;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic over GF(2): r*x mod (x16+x5+x3+x2+1), plus data.
  function automatic logic [15:0] poly_step(input logic [15:0] r, input logic [15:0] d);
    int unsigned v;
    v = 32'(r) * 2;
    if (v >= 32'h10000) v = v ^ 32'h1002D;
    return 16'(v) ^ d;
  endfunction

  // Monitor: sample the handshake at the edge, compare just after it.
  logic [15:0] cur_sig;
  logic [5:0]  cur_cnt;
  logic        done_prev = 1'b0;
  always @(posedge clk) begin
    logic acc;
    logic rst_edge;
    acc_t e;
    res_t r;
    acc      = bus.in_valid && bus.in_ready && rst_n;
    rst_edge = !rst_n;
    #1;
    if (rst_edge) begin
      chk("rst_signature", 32'(bus.signature), 32'(SEED));
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_pass", 32'(bus.pass), 32'd0);
      cur_sig   = SEED;
      cur_cnt   = '0;
      done_prev = 1'b0;
    end else begin
      if (acc) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_accept", 32'd1, 32'd0);
        end else begin
          e = acc_q.pop_front();
          chk("acc_signature", 32'(bus.signature), 32'(e.sig));
          chk("acc_count", 32'(bus.count), 32'(e.cnt));
          cur_sig = e.sig;
          cur_cnt = e.cnt;
        end
      end else begin
        chk("hold_signature", 32'(bus.signature), 32'(cur_sig));
        chk("hold_count", 32'(bus.count), 32'(cur_cnt));
      end
      if (bus.done && !done_prev) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = done_q.pop_front();
          chk("done_pass", 32'(bus.pass), 32'(r.pass));
          chk("done_signature", 32'(bus.signature), 32'(r.sig));
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic send(input logic [15:0] d);
    acc_t e;
    res_t r;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.product  = d;
    if (m_cnt < int'(NUM)) begin
      m_sig = poly_step(m_sig, d);
      m_cnt++;
      e.sig = m_sig;
      e.cnt = 6'(m_cnt);
      acc_q.push_back(e);
      if (m_cnt == int'(NUM)) begin
        r.pass = (m_sig == g_exp);
        r.sig  = m_sig;
        done_q.push_back(r);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.product  = 16'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'($urandom);
    bus.product  = 16'($urandom);
    @(posedge clk);
    #2;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_pass", 32'(bus.pass), 32'd0);
    chk("reset_sig_const", 32'(bus.signature), 32'h8000);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    m_sig = SEED;
    m_cnt = 0;
  endtask

  // Full run; expected_signature holds a wrong value until the last product so
  // that only its value during COMPARE matters.
  task automatic run_full(input logic [15:0] p[NUM], input bit gaps, input logic [15:0] exp);
    g_exp = exp;
    bus.expected_signature = ~exp;
    for (int i = 0; i < int'(NUM); i++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) idle();
      end
      if (i == int'(NUM) - 1) bus.expected_signature = exp;
      send(p[i]);
    end
    @(posedge clk);
    #2;
    chk("last_count", 32'(bus.count), 32'(NUM));
    chk("compare_in_ready", 32'(bus.in_ready), 32'd0);
    chk("compare_done", 32'(bus.done), 32'd0);
    idle();
    @(posedge clk);
    #2;
    chk("final_done", 32'(bus.done), 32'd1);
    bus.expected_signature = ~exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] st;
    logic [15:0] sig_before;
    bus.in_valid           = 1'b0;
    bus.product            = '0;
    bus.expected_signature = '0;

    st = 16'hACE1;
    for (int i = 0; i < int'(NUM); i++) begin
      st = poly_step(st, 16'h0000);
      gen_p[i] = 16'(int'(st[15:8]) * int'(st[7:0]));
    end
    golden = SEED;
    for (int i = 0; i < int'(NUM); i++) golden = poly_step(golden, gen_p[i]);
    flip_p = gen_p;
    flip_p[16] = flip_p[16] ^ 16'h0080;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("init_in_ready", 32'(bus.in_ready), 32'd1);

    // Known-answer steps from the seed
    send(16'h0000);
    @(posedge clk); #2;
    chk("kat_zero1", 32'(bus.signature), 32'h002D);
    chk("kat_count1", 32'(bus.count), 32'd1);
    chk("kat_ready1", 32'(bus.in_ready), 32'd1);
    send(16'h0000);
    @(posedge clk); #2;
    chk("kat_zero2", 32'(bus.signature), 32'h005A);
    idle();
    do_reset();
    send(16'h0001);
    @(posedge clk); #2;
    chk("kat_data_bit0", 32'(bus.signature), 32'h002C);
    idle();

    // Clean gap-free run, then ignored pulses in DONE
    do_reset();
    run_full(gen_p, 1'b0, golden);
    chk("clean_pass", 32'(bus.pass), 32'd1);
    chk("clean_sig", 32'(bus.signature), 32'(golden));
    for (int i = 0; i < 40; i++) send(16'($urandom));
    idle();
    @(posedge clk); #2;
    chk("frozen_sig", 32'(bus.signature), 32'(golden));
    chk("frozen_count", 32'(bus.count), 32'(NUM));
    chk("frozen_done", 32'(bus.done), 32'd1);
    chk("frozen_pass", 32'(bus.pass), 32'd1);

    // Corrupted product #17
    do_reset();
    run_full(flip_p, 1'b0, golden);
    chk("flip_pass", 32'(bus.pass), 32'd0);
    n_checks++;
    if (bus.signature == golden) begin
      n_errors++;
      $display("FAIL flip_sig_differs: got %0h which equals golden %0h", bus.signature, golden);
    end

    // Random gaps must give the same signature
    do_reset();
    run_full(gen_p, 1'b1, golden);
    chk("gap_pass", 32'(bus.pass), 32'd1);
    chk("gap_sig", 32'(bus.signature), 32'(golden));

    // Reset mid-run, then a clean restart
    do_reset();
    for (int i = 0; i < 10; i++) send(gen_p[i]);
    sig_before = m_sig;
    @(posedge clk); #2;
    chk("midrun_sig", 32'(bus.signature), 32'(sig_before));
    do_reset();
    chk("midrun_rst_count", 32'(bus.count), 32'd0);
    chk("midrun_rst_sig", 32'(bus.signature), 32'h8000);
    run_full(gen_p, 1'b0, golden);
    chk("restart_pass", 32'(bus.pass), 32'd1);
    chk("restart_sig", 32'(bus.signature), 32'(golden));

    // Reset out of DONE
    do_reset();
    chk("done_rst_done", 32'(bus.done), 32'd0);
    chk("done_rst_pass", 32'(bus.pass), 32'd0);
    repeat (3) idle();
    @(posedge clk); #2;

    chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
